adc_responder: RTL and testbench
================================

ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter CONV_CYCLES, default 80, i_clk cycles of conversion time (1.6 us at 50 MHz); legal range 1..255.
REQ-002 i_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_sample  input  12  value to be reported by the emulated converter.
REQ-005 i_convst  input  1  conversion start pin from the ADC master; asynchronous to i_clk.
REQ-006 i_sck  input  1  serial clock pin from the master; asynchronous to i_clk.
REQ-007 i_sdi  input  1  serial config bits from the master.
REQ-008 o_sdo  output  1  serial sample data to the master.
REQ-009 o_busy  output  1  high while converting.
REQ-010 o_cfg  output  6  last complete config word received.
REQ-011 o_cfg_valid  output  1  one-cycle pulse when o_cfg updates.
REQ-012 o_frame_done  output  1  one-cycle pulse at end of a 12-bit frame.
REQ-013 o_timing_err  output  1  one-cycle pulse on a protocol timing violation.

Function
REQ-014 i_convst and i_sck SHALL each pass a 2-flop synchronizer plus edge-detect register; rise/fall pulses occur in the 3rd i_clk edge after a pin change.
REQ-015 FSM states SHALL be IDLE, CONVERTING, SHIFTING, DONE.
REQ-016 IDLE: on convst rise, latch i_sample into shadow register, clear counters, go CONVERTING; sck edges ignored; o_sdo = 0.
REQ-017 CONVERTING: o_busy = 1; conversion counter increments each cycle; at count == CONV_CYCLES, leave once synchronized convst is low, else wait.
REQ-018 CONVERTING exit: go SHIFTING with o_sdo = shadow[0] in the same cycle the state changes.
REQ-019 SHIFTING: on each sck rise, capture i_sdi into cfg shift register bit index rx_idx (LSB first) while rx_idx <= 5; increment the 4-bit edge counter.
REQ-020 SHIFTING: on each sck fall, advance bit index; o_sdo = shadow[index], LSB first, index saturating at 11.
REQ-021 On the 12th sck rise: go DONE; bits 6..11 of i_sdi are ignored.
REQ-022 DONE (one cycle): o_frame_done = 1, o_cfg <= captured 6 bits, o_cfg_valid = 1, o_sdo = 0; go IDLE.
REQ-023 Convst rise while SHIFTING or DONE SHALL abort the frame (o_cfg unchanged, no o_frame_done), latch new sample, go CONVERTING.
REQ-024 Simultaneous sck rise and convst rise: convst wins.
REQ-025 Sample latched at convst rise is held stable for the whole frame regardless of i_sample changes.

Reset
REQ-026 i_rst_n low SHALL immediately force state IDLE, all outputs 0, o_cfg = 0, counters, shadow and synchronizers 0, including mid-conversion or mid-frame.
REQ-027 After reset release, a convst already high SHALL NOT register as a rise until it has been seen low.

Configuration
REQ-028 Macro ADC_RESP_TIMING_CHECK_EN defined: o_timing_err pulses when convst falls in CONVERTING before count reaches CONV_CYCLES, or when convst rises in SHIFTING (abort); transitions unchanged.
REQ-029 Macro undefined: o_timing_err tied 0, check logic absent; all other behaviour identical.

Structure
REQ-030 Package adc_if_pkg SHALL hold state enum, ADC_DATA_W = 12, ADC_CFG_W = 6, shared with the master.
REQ-031 One sub-module sync_edge_det (2-flop sync + rise/fall pulses), instantiated for i_convst and i_sck.

Verification
REQ-032 i_sample = 12'hA5C, convst high 100 cycles then low, 12 sck periods of 50 cycles, i_sdi word 6'b101101 -> master reads 12'hA5C, o_cfg = 6'b101101, single o_cfg_valid and o_frame_done.
REQ-033 i_sample changed to 12'h000 mid-frame after latching 12'hFFF -> all 12 bits read as 1.
REQ-034 convst low after 40 cycles (CONV_CYCLES = 80) -> o_sdo bit 0 only after counter reaches 80; o_timing_err pulse only with macro defined.
REQ-035 convst rise after 5 sck bits -> abort, no o_cfg_valid, next full frame returns new sample correctly.
REQ-036 i_rst_n asserted mid-frame -> outputs 0 asynchronously; convst held high through release -> no conversion until low-high seen.
REQ-037 sck toggling in IDLE and CONVERTING (8 pulses) -> ignored; subsequent frame decodes correctly.

Source files
------------

// File: rtl/adc_if_pkg.sv
// Types and widths shared by the ADC responder and the ADC master model.
// Serial frames are 12 sample bits out and 6 configuration bits in, both LSB first.
package adc_if_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CFG_W  = 6;
  localparam int ADC_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONVERTING,
    SHIFTING,
    DONE
  } adc_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge detector for one asynchronous input pin.
// Edges are reported only after the pin has been seen low once since reset.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] fill_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= i_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
      // sync2_q holds a genuine pin sample only once fill_q reaches 2.
      if (fill_q == 2'd2 && !sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign o_rise = armed_q & sync2_q & ~prev_q;
  assign o_fall = armed_q & ~sync2_q & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Emulated SPI-style ADC: convst starts a conversion, then 12 sck periods shift the sample out.
// Define ADC_RESP_TIMING_CHECK_EN to enable the o_timing_err protocol checker.
module adc_responder
  import adc_if_pkg::*;
#(
  parameter int CONV_CYCLES = 80
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADC_DATA_W-1:0] i_sample,
  input  logic                  i_convst,
  input  logic                  i_sck,
  input  logic                  i_sdi,
  output logic                  o_sdo,
  output logic                  o_busy,
  output logic [ADC_CFG_W-1:0]  o_cfg,
  output logic                  o_cfg_valid,
  output logic                  o_frame_done,
  output logic                  o_timing_err
);

  localparam logic [7:0]           CONV_LAST = 8'(CONV_CYCLES);
  localparam logic [ADC_IDX_W-1:0] LAST_IDX  = ADC_IDX_W'(ADC_DATA_W - 1);

  logic cv_rise, cv_fall, sck_rise, sck_fall;
  logic start_conv, convst_low;

  adc_state_e            state_q;
  logic [ADC_DATA_W-1:0] shadow_q;
  logic [ADC_CFG_W-1:0]  cfg_sr_q;
  logic [ADC_CFG_W-1:0]  cfg_q;
  logic [7:0]            conv_cnt_q;
  logic [ADC_IDX_W-1:0]  edge_cnt_q;
  logic [ADC_IDX_W-1:0]  tx_idx_q;
  logic [ADC_IDX_W-1:0]  tx_idx_d;
  logic                  convst_hi_q;
  logic                  sdo_q;
  logic                  busy_q;
  logic                  cfg_valid_q;
  logic                  frame_done_q;

  sync_edge_det u_sync_convst (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_pin  (i_convst),
    .o_rise (cv_rise),
    .o_fall (cv_fall)
  );

  sync_edge_det u_sync_sck (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_pin  (i_sck),
    .o_rise (sck_rise),
    .o_fall (sck_fall)
  );

  // A convst rise anywhere except mid-conversion (re)starts a conversion and aborts any frame.
  assign start_conv = cv_rise && (state_q != CONVERTING);
  assign convst_low = cv_fall || (!cv_rise && !convst_hi_q);
  assign tx_idx_d   = (tx_idx_q >= LAST_IDX) ? tx_idx_q : tx_idx_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      cfg_sr_q     <= '0;
      cfg_q        <= '0;
      conv_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      tx_idx_q     <= '0;
      convst_hi_q  <= 1'b0;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      cfg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cfg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (cv_rise) begin
        convst_hi_q <= 1'b1;
      end else if (cv_fall) begin
        convst_hi_q <= 1'b0;
      end

      if (start_conv) begin
        state_q    <= CONVERTING;
        shadow_q   <= i_sample;
        cfg_sr_q   <= '0;
        conv_cnt_q <= '0;
        edge_cnt_q <= '0;
        tx_idx_q   <= '0;
        busy_q     <= 1'b1;
        sdo_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            sdo_q <= 1'b0;
          end
          CONVERTING: begin
            if (conv_cnt_q != CONV_LAST) begin
              conv_cnt_q <= conv_cnt_q + 8'd1;
            end else if (convst_low) begin
              state_q <= SHIFTING;
              busy_q  <= 1'b0;
              sdo_q   <= shadow_q[0];
            end
          end
          SHIFTING: begin
            if (sck_rise) begin
              for (int b = 0; b < ADC_CFG_W; b++) begin
                if (edge_cnt_q == ADC_IDX_W'(b)) begin
                  cfg_sr_q[b] <= i_sdi;
                end
              end
              edge_cnt_q <= edge_cnt_q + 1'b1;
              if (edge_cnt_q == LAST_IDX) begin
                state_q <= DONE;
                sdo_q   <= 1'b0;
              end
            end else if (sck_fall) begin
              tx_idx_q <= tx_idx_d;
              sdo_q    <= shadow_q[tx_idx_d];
            end
          end
          DONE: begin
            cfg_q        <= cfg_sr_q;
            cfg_valid_q  <= 1'b1;
            frame_done_q <= 1'b1;
            sdo_q        <= 1'b0;
            state_q      <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ADC_RESP_TIMING_CHECK_EN
  logic timing_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timing_err_q <= 1'b0;
    end else begin
      timing_err_q <= (state_q == CONVERTING && cv_fall && conv_cnt_q != CONV_LAST) ||
                      (state_q == SHIFTING && cv_rise);
    end
  end

  assign o_timing_err = timing_err_q;
`else
  assign o_timing_err = 1'b0;
`endif

  assign o_sdo        = sdo_q;
  assign o_busy       = busy_q;
  assign o_cfg        = cfg_q;
  assign o_cfg_valid  = cfg_valid_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_adc_responder.sv
// Self-checking bench for adc_responder: a master model drives convst/sck/sdi and compares
// read-back words, config words and pulse counts against values the bench itself chose.
module tb_adc_responder;

  localparam int CONV = 80;
  localparam int HALF = 25;
`ifdef ADC_RESP_TIMING_CHECK_EN
  localparam int TE_ON = 1;
`else
  localparam int TE_ON = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [11:0] i_sample = '0;
  logic        i_convst = 1'b0;
  logic        i_sck = 1'b0;
  logic        i_sdi = 1'b0;
  logic        o_sdo, o_busy, o_cfg_valid, o_frame_done, o_timing_err;
  logic [5:0]  o_cfg;

  int errors = 0;
  int checks = 0;
  int n_valid = 0, n_done = 0, n_err = 0;
  int busy_run = 0, last_busy_len = 0;

  // Reference model state: what the master expects the responder to hold.
  logic [11:0] exp_sample;
  logic [5:0]  exp_cfg = '0;

  adc_responder #(.CONV_CYCLES(CONV)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sample    (i_sample),
    .i_convst    (i_convst),
    .i_sck       (i_sck),
    .i_sdi       (i_sdi),
    .o_sdo       (o_sdo),
    .o_busy      (o_busy),
    .o_cfg       (o_cfg),
    .o_cfg_valid (o_cfg_valid),
    .o_frame_done(o_frame_done),
    .o_timing_err(o_timing_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_cfg_valid === 1'b1) n_valid++;
    if (o_frame_done === 1'b1) n_done++;
    if (o_timing_err === 1'b1) n_err++;
    if (o_busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_conv(input logic [11:0] s, input int hold);
    @(negedge i_clk);
    i_sample   = s;
    exp_sample = s;
    i_convst   = 1'b1;
    repeat (hold) @(negedge i_clk);
    i_convst = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (o_busy !== 1'b0 && k < 600) begin
      @(negedge i_clk);
      k++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_timeout: busy=%b after %0d cycles, required 0", tag, o_busy, k);
    end
  endtask

  task automatic shift_bits(input int nbits, input logic [5:0] cfg, input bit scramble,
                            output logic [11:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge i_clk);
      i_sdi = (i < 6) ? cfg[i] : 1'($urandom);
      i_sck = 1'b0;
      if (scramble) i_sample = 12'($urandom);
      repeat (HALF) @(negedge i_clk);
      rd[i] = o_sdo;
      i_sck = 1'b1;
      repeat (HALF) @(negedge i_clk);
    end
    i_sck = 1'b0;
    repeat (10) @(negedge i_clk);
  endtask

  task automatic check_frame(input string tag, input logic [11:0] rd, input int nv0, input int nd0);
    checks++;
    if (rd !== exp_sample) begin
      errors++;
      $display("FAIL %s_data: read %h, required %h", tag, rd, exp_sample);
    end
    checks++;
    if (o_cfg !== exp_cfg) begin
      errors++;
      $display("FAIL %s_cfg: got %b, required %b", tag, o_cfg, exp_cfg);
    end
    checks++;
    if (n_valid - nv0 != 1) begin
      errors++;
      $display("FAIL %s_cfg_valid: %0d pulses, required 1", tag, n_valid - nv0);
    end
    checks++;
    if (n_done - nd0 != 1) begin
      errors++;
      $display("FAIL %s_frame_done: %0d pulses, required 1", tag, n_done - nd0);
    end
  endtask

  task automatic full_frame(input string tag, input logic [11:0] s, input logic [5:0] cfg,
                            input bit scramble);
    logic [11:0] rd;
    int nv0 = n_valid, nd0 = n_done, ne0 = n_err;
    start_conv(s, 100);
    wait_ready(tag);
    shift_bits(12, cfg, scramble, rd);
    exp_cfg = cfg;
    check_frame(tag, rd, nv0, nd0);
    checks++;
    if (n_err != ne0) begin
      errors++;
      $display("FAIL %s_timing_err: %0d pulses, required 0", tag, n_err - ne0);
    end
    $display("frame %s: sample=%h cfg=%b read=%h", tag, s, cfg, rd);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_sdo, o_busy, o_cfg_valid, o_frame_done, o_timing_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {o_sdo, o_busy, o_cfg_valid, o_frame_done, o_timing_err});
    end
    checks++;
    if (o_cfg !== 6'b0) begin
      errors++;
      $display("FAIL reset_cfg: got %b, required 000000", o_cfg);
    end
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_sdo !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b sdo=%b, required 0 0", o_busy, o_sdo);
    end
    $display("reset: checked");
  endtask

  task automatic test_basic;
    full_frame("basic", 12'hA5C, 6'b101101, 1'b0);
  endtask

  task automatic test_sample_hold;
    logic [11:0] rd;
    int nv0 = n_valid, nd0 = n_done;
    start_conv(12'hFFF, 100);
    i_sample = 12'h000;
    wait_ready("hold");
    shift_bits(12, 6'b010011, 1'b0, rd);
    exp_cfg = 6'b010011;
    check_frame("hold", rd, nv0, nd0);
    $display("frame hold: latched=fff read=%h", rd);
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) begin
      full_frame("random", 12'($urandom), 6'($urandom), 1'b1);
    end
  endtask

  task automatic test_early_low;
    logic [11:0] rd;
    int nv0 = n_valid, nd0 = n_done, ne0 = n_err;
    start_conv(12'($urandom), 40);
    wait_ready("early");
    repeat (2) @(negedge i_clk);
    checks++;
    if (last_busy_len < CONV || last_busy_len > CONV + 2) begin
      errors++;
      $display("FAIL early_busy_len: %0d cycles, required %0d..%0d", last_busy_len, CONV, CONV + 2);
    end
    checks++;
    if (n_err - ne0 != TE_ON) begin
      errors++;
      $display("FAIL early_timing_err: %0d pulses, required %0d", n_err - ne0, TE_ON);
    end
    shift_bits(12, 6'b111000, 1'b1, rd);
    exp_cfg = 6'b111000;
    check_frame("early", rd, nv0, nd0);
    $display("frame early: busy_len=%0d read=%h", last_busy_len, rd);
  endtask

  task automatic test_abort;
    logic [11:0] rd;
    logic [5:0]  old_cfg = exp_cfg;
    int nv0 = n_valid, nd0 = n_done, ne0 = n_err;
    start_conv(12'h3C7, 100);
    wait_ready("abort1");
    shift_bits(5, ~old_cfg, 1'b0, rd);
    start_conv(12'h58E, 100);
    wait_ready("abort2");
    checks++;
    if (n_valid != nv0 || n_done != nd0) begin
      errors++;
      $display("FAIL abort_pulses: valid=%0d done=%0d, required 0 0", n_valid - nv0, n_done - nd0);
    end
    checks++;
    if (o_cfg !== old_cfg) begin
      errors++;
      $display("FAIL abort_cfg_kept: got %b, required %b", o_cfg, old_cfg);
    end
    checks++;
    if (n_err - ne0 != TE_ON) begin
      errors++;
      $display("FAIL abort_timing_err: %0d pulses, required %0d", n_err - ne0, TE_ON);
    end
    shift_bits(12, 6'b100110, 1'b1, rd);
    exp_cfg = 6'b100110;
    check_frame("abort", rd, nv0, nd0);
    $display("frame abort: new sample read=%h", rd);
  endtask

  task automatic test_sck_ignored;
    logic [11:0] rd;
    int nv0 = n_valid, nd0 = n_done;
    for (int p = 0; p < 8; p++) begin
      @(negedge i_clk) i_sck = 1'b1;
      repeat (5) @(negedge i_clk);
      i_sck = 1'b0;
      repeat (5) @(negedge i_clk);
    end
    checks++;
    if (n_done != nd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL sck_idle: done=%0d busy=%b, required 0 0", n_done - nd0, o_busy);
    end
    @(negedge i_clk);
    i_sample   = 12'h6D2;
    exp_sample = 12'h6D2;
    i_convst   = 1'b1;
    for (int p = 0; p < 8; p++) begin
      i_sck = 1'b1;
      repeat (5) @(negedge i_clk);
      i_sck = 1'b0;
      repeat (5) @(negedge i_clk);
    end
    repeat (20) @(negedge i_clk);
    i_convst = 1'b0;
    wait_ready("sck");
    shift_bits(12, 6'b001011, 1'b0, rd);
    exp_cfg = 6'b001011;
    check_frame("sck", rd, nv0, nd0);
    $display("frame sck_ignored: read=%h", rd);
  endtask

  task automatic test_reset_mid;
    logic [11:0] rd;
    int hits = 0;
    start_conv(12'hFFF, 100);
    wait_ready("rstmid");
    shift_bits(5, 6'b110101, 1'b0, rd);
    checks++;
    if (o_sdo !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_sdo: got %b, required 1", o_sdo);
    end
    @(negedge i_clk);
    #2;
    i_rst_n  = 1'b0;
    i_convst = 1'b1;
    #1;
    checks++;
    if ({o_sdo, o_busy, o_cfg_valid, o_frame_done} !== 4'b0 || o_cfg !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_async: flags=%b cfg=%b, required 0000 000000",
               {o_sdo, o_busy, o_cfg_valid, o_frame_done}, o_cfg);
    end
    exp_cfg = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge i_clk);
      if (o_busy === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL rstmid_held_convst: busy high %0d cycles, required 0", hits);
    end
    i_convst = 1'b0;
    repeat (10) @(negedge i_clk);
    full_frame("after_reset", 12'h1E4, 6'b011110, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sample_hold();
    test_random();
    test_early_low();
    test_abort();
    test_sck_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
